// File: rtl/cpu8_alu.sv
// cpu8_alu: 8-bit ALU with combinational RESULT/NZVC and a clocked carry register.
// The carry register and ADC/SBC exist only with ALU_CARRY_CHAIN_EN; otherwise 110/111 are XOR/NOT.
module cpu8_alu (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] SEL,
    input  logic       FLAG_WE,
    output logic [7:0] RESULT,
    output logic [3:0] NZVC,
    output logic       CARRY_Q
);
`ifdef ALU_CARRY_CHAIN_EN
    localparam bit CHAIN = 1'b1;
    logic carry_q, carry_d;
    assign carry_d = FLAG_WE ? NZVC[0] : carry_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) carry_q <= 1'b0;
        else carry_q <= carry_d;
`else
    localparam bit CHAIN = 1'b0;
    logic carry_q;
    logic unused_ins;
    assign carry_q = 1'b0;
    assign unused_ins = &{1'b0, clk, reset, FLAG_WE};
`endif
    logic [7:0] op_b, logic_r;
    logic [8:0] sum;
    logic       sub, cin, is_logic, v;
    // INC/DEC reuse the ADD/SUB path with a constant 1 operand
    assign op_b     = (SEL[2:1] == 2'b10) ? 8'h01 : B;
    assign sub      = SEL[0];
    assign cin      = (SEL[2:1] == 2'b11) ? carry_q : 1'b0;
    assign sum      = sub ? {1'b0, A} - {1'b0, op_b} - {8'b0, cin}
                          : {1'b0, A} + {1'b0, op_b} + {8'b0, cin};
    assign is_logic = (SEL[2:1] == 2'b01) || (!CHAIN && SEL[2:1] == 2'b11);
    assign logic_r  = (SEL == 3'b010) ? A & B : (SEL == 3'b011) ? A | B : SEL[0] ? ~A : A ^ B;
    assign RESULT   = is_logic ? logic_r : sum[7:0];
    assign v        = ((A[7] ^ op_b[7]) == sub) && (RESULT[7] != A[7]);
    assign NZVC     = {RESULT[7], RESULT == 8'h00, !is_logic && v, !is_logic && sum[8]};
    assign CARRY_Q  = carry_q;
endmodule

// File: tb/tb_cpu8_alu.sv
// tb_cpu8_alu: table-driven checks of cpu8_alu plus hand-written carry register sequences.
// Expectations for SEL=110/111 and CARRY_Q follow ALU_CARRY_CHAIN_EN.
module tb_cpu8_alu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic [2:0] sel = 3'b000;
    logic       flag_we = 1'b0;
    logic [7:0] result;
    logic [3:0] nzvc;
    logic       carry_q;
    int         n_cmp = 0, n_bad = 0;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] f;
    } vec_t;
    vec_t tv [16];

    cpu8_alu dut (
        .clk(clk), .reset(rst_n), .A(a), .B(b), .SEL(sel), .FLAG_WE(flag_we),
        .RESULT(result), .NZVC(nzvc), .CARRY_Q(carry_q)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic op(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
        sel = s;
        a = x;
        b = y;
        #1;
    endtask

    task automatic check_out(input string nm, input logic [7:0] r, input logic [3:0] f);
        cmp({nm, " result"}, int'(result), int'(r));
        cmp({nm, " nzvc"}, int'(nzvc), int'(f));
    endtask

    initial begin
        tv[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b1010};
        tv[1]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b0101};
        tv[2]  = '{3'b000, 8'h10, 8'h20, 8'h30, 4'b0000};
        tv[3]  = '{3'b001, 8'h00, 8'h01, 8'hFF, 4'b1001};
        tv[4]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0010};
        tv[5]  = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b0100};
        tv[6]  = '{3'b001, 8'h10, 8'h20, 8'hF0, 4'b1001};
        tv[7]  = '{3'b010, 8'hF0, 8'h0F, 8'h00, 4'b0100};
        tv[8]  = '{3'b010, 8'hFF, 8'h81, 8'h81, 4'b1000};
        tv[9]  = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 4'b1000};
        tv[10] = '{3'b011, 8'h00, 8'h00, 8'h00, 4'b0100};
        tv[11] = '{3'b100, 8'hFF, 8'h55, 8'h00, 4'b0101};
        tv[12] = '{3'b100, 8'h7F, 8'hFF, 8'h80, 4'b1010};
        tv[13] = '{3'b101, 8'h00, 8'h33, 8'hFF, 4'b1001};
        tv[14] = '{3'b101, 8'h80, 8'h00, 8'h7F, 4'b0010};
        tv[15] = '{3'b000, 8'h80, 8'h80, 8'h00, 4'b0111};

        #2;
        cmp("reset carry", int'(carry_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            op(tv[i].sel, tv[i].a, tv[i].b);
            check_out($sformatf("vec%0d", i), tv[i].res, tv[i].f);
        end

`ifdef ALU_CARRY_CHAIN_EN
        // ADC with clear carry behaves as ADD
        @(negedge clk);
        op(3'b110, 8'h7F, 8'h01);
        check_out("adc c0", 8'h80, 4'b1010);
        op(3'b000, 8'hFF, 8'h01);
        flag_we = 1'b1;
        @(posedge clk);
        #1 flag_we = 1'b0;
        cmp("carry set", int'(carry_q), 1);
        op(3'b110, 8'h00, 8'h00);
        check_out("adc c1", 8'h01, 4'b0000);
        op(3'b111, 8'h00, 8'h00);
        check_out("sbc c1", 8'hFF, 4'b1001);
        op(3'b111, 8'h10, 8'h05);
        check_out("sbc c1b", 8'h0A, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        cmp("async reset carry", int'(carry_q), 0);
        op(3'b110, 8'h00, 8'h00);
        check_out("adc after rst", 8'h00, 4'b0100);
        op(3'b000, 8'hFF, 8'h01);
        flag_we = 1'b1;
        @(posedge clk);
        #1;
        cmp("we ignored in reset", int'(carry_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp("capture cyc1", int'(carry_q), 1);
        op(3'b000, 8'h01, 8'h01);
        @(posedge clk);
        #1;
        cmp("capture cyc2", int'(carry_q), 0);
        op(3'b001, 8'h00, 8'h01);
        @(posedge clk);
        #1 flag_we = 1'b0;
        cmp("capture borrow", int'(carry_q), 1);
        op(3'b000, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        cmp("hold carry", int'(carry_q), 1);
`else
        @(negedge clk);
        op(3'b110, 8'hAA, 8'hFF);
        check_out("xor", 8'h55, 4'b0000);
        op(3'b110, 8'h5A, 8'h5A);
        check_out("xor zero", 8'h00, 4'b0100);
        op(3'b111, 8'h00, 8'h12);
        check_out("not", 8'hFF, 4'b1000);
        op(3'b111, 8'hFF, 8'h00);
        check_out("not zero", 8'h00, 4'b0100);
        op(3'b000, 8'hFF, 8'h01);
        flag_we = 1'b1;
        repeat (3) @(posedge clk);
        #1 flag_we = 1'b0;
        cmp("carry tied 0", int'(carry_q), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
